// File: rtl/calc_pkg.sv
// Shared calculator definitions: core status codes, the blank digit code and
// active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package calc_pkg;

   typedef enum logic [1:0] {
      ERRO    = 2'b00,
      PRONTA  = 2'b01,
      OCUPADA = 2'b10
   } status_e;

   localparam logic [3:0] BLANK = 4'hF;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Codes 10..15 carry no glyph and fall through to blank.
   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/calc_display_if.sv
// Core-to-display bus: digit writes and status from the core, and the
// multiplexed anode/segment drive toward the display.
interface calc_display_if #(
   parameter int DIGITS = 8
);
   logic [1:0]        status;
   logic [3:0]        pos;
   logic [3:0]        dig;
   logic [DIGITS-1:0] an;
   logic [6:0]        seg;
   logic              dp;

   modport master (output status, output pos, output dig,
                   input  an, input seg, input dp);
   modport slave  (input  status, input pos, input dig,
                   output an, output seg, output dp);
endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment decoder with a forced-blank input.
module seg7_decode
   import calc_pkg::*;
(
   input  logic [3:0] val,
   input  logic       blank,
   output logic [6:0] seg
);

   assign seg = blank ? SEG_BLANK : seg_of(val);

endmodule

// File: rtl/calc_display.sv
// Eight-digit multiplexed display driver: captures core digit writes, blanks
// leading zeros, overlays "Err" on error and scans active-low anodes.
module calc_display
   import calc_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 50000
) (
   input  logic           clock,
   input  logic           reset,
   calc_display_if.slave  bus
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [3:0]        digit_buf [DIGITS];
   logic [3:0]        pos_q;
   logic [CW-1:0]     div_cnt;
   logic [IW-1:0]     idx;
   logic [DIGITS-1:0] zero_blank;
   logic [6:0]        digit_seg;
   logic [6:0]        seg_nxt;
   logic [DIGITS-1:0] an_nxt;
   logic              dp_nxt;
   logic              pos_valid;
   logic              frame_start;
   logic [DIGITS-1:0] an_p1;
   logic [6:0]        seg_p1;
   logic              dp_p1;

   assign pos_valid   = 32'(bus.pos) < 32'(DIGITS);
   assign frame_start = (bus.pos == 4'd0) && (pos_q != 4'd0);

   // Walk down from the top digit; a zero is blanked only while everything above is empty.
   always_comb begin
      logic tail_empty;
      tail_empty = 1'b1;
      zero_blank = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_blank[i] = (digit_buf[i] == 4'd0) && tail_empty;
         tail_empty    = tail_empty &&
                         ((digit_buf[i] == 4'd0) || (digit_buf[i] > 4'd9));
      end
   end

   seg7_decode u_dec (
      .val   (digit_buf[idx]),
      .blank (zero_blank[idx]),
      .seg   (digit_seg)
   );

   always_comb begin
      seg_nxt = digit_seg;
      if (bus.status == ERRO) begin
         if (idx == IW'(2))
            seg_nxt = SEG_E;
         else if (idx < IW'(2))
            seg_nxt = SEG_R;
         else
            seg_nxt = SEG_BLANK;
      end
      for (int i = 0; i < DIGITS; i++)
         an_nxt[i] = (idx != IW'(i));
      dp_nxt = !((idx == '0) && (bus.status == OCUPADA));
   end

   // p1: registered display drive, buffer capture and scan counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DIGITS; i++)
            digit_buf[i] <= BLANK;
         pos_q   <= '0;
         div_cnt <= '0;
         idx     <= '0;
         an_p1   <= '1;
         seg_p1  <= SEG_BLANK;
         dp_p1   <= 1'b1;
      end else begin
         pos_q <= bus.pos;
         if (frame_start) begin
            for (int i = 1; i < DIGITS; i++)
               digit_buf[i] <= BLANK;
            digit_buf[0] <= bus.dig;
         end else if (pos_valid) begin
            digit_buf[bus.pos[IW-1:0]] <= bus.dig;
         end

         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         an_p1  <= an_nxt;
         seg_p1 <= seg_nxt;
         dp_p1  <= dp_nxt;
      end
   end

   assign bus.an  = an_p1;
   assign bus.seg = seg_p1;
   assign bus.dp  = dp_p1;

endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display with a short refresh divider.
module tb_calc_display;

   localparam int DIGITS = 8;
   localparam int RD     = 4;

   localparam logic [6:0] B  = 7'b1111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SE = 7'b0000110;
   localparam logic [6:0] SR = 7'b0101111;

   logic clock = 1'b0;
   logic reset = 1'b1;

   calc_display_if #(.DIGITS(DIGITS)) bus ();

   calc_display #(.DIGITS(DIGITS), .REFRESH_DIV(RD)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_run  = 0;
   int n_fail = 0;

   logic [15:0] sb_q [$];
   int          mbuf [DIGITS];
   int          mpos_q;
   int          mdiv;
   int          midx;
   logic [7:0]  shown [DIGITS];

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] dec(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [15:0] model_out(input logic [1:0] st);
      logic [7:0] a;
      logic [6:0] s;
      logic       d;
      logic       z;
      a = 8'hFF;
      a[midx] = 1'b0;
      if (st == 2'b00) begin
         if (midx == 2)     s = 7'b0000110;
         else if (midx < 2) s = 7'b0101111;
         else               s = 7'b1111111;
      end else begin
         z = (midx != 0) && (mbuf[midx] == 0);
         for (int j = midx + 1; j < DIGITS; j++)
            if (mbuf[j] >= 1 && mbuf[j] <= 9) z = 1'b0;
         s = z ? 7'b1111111 : dec(mbuf[midx]);
      end
      d = !(midx == 0 && st == 2'b10);
      return {a, s, d};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DIGITS; i++) mbuf[i] = 15;
      mpos_q = 0;
      mdiv   = 0;
      midx   = 0;
      sb_q.delete();
   endtask

   task automatic model_update(input int p, input int d);
      if (p == 0 && mpos_q != 0) begin
         for (int i = 1; i < DIGITS; i++) mbuf[i] = 15;
         mbuf[0] = d;
      end else if (p < DIGITS) begin
         mbuf[p] = d;
      end
      mpos_q = p;
      if (mdiv == RD - 1) begin
         mdiv = 0;
         midx = (midx + 1) % DIGITS;
      end else begin
         mdiv++;
      end
   endtask

   // Called at a negedge: drive, predict, let one edge pass, compare.
   task automatic step(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
      logic [15:0] exp;
      logic [7:0]  m;
      bus.status = st;
      bus.pos    = p;
      bus.dig    = d;
      sb_q.push_back(model_out(st));
      model_update(int'(p), int'(d));
      @(negedge clock);
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 16'h0, 16'h1);
      end else begin
         exp = sb_q.pop_front();
         check_val("scan", {bus.an, bus.seg, bus.dp}, exp);
      end
      for (int i = 0; i < DIGITS; i++) begin
         m = 8'h01 << i;
         if (bus.an == ~m) shown[i] = {bus.seg, bus.dp};
      end
   endtask

   task automatic run(input int n, input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
      for (int k = 0; k < n; k++) step(st, p, d);
   endtask

   task automatic clear_shown();
      for (int i = 0; i < DIGITS; i++) shown[i] = 8'h00;
   endtask

   task automatic scene(input string tag, input logic [55:0] segs, input logic [7:0] dps);
      for (int i = 0; i < DIGITS; i++)
         check_val($sformatf("%s[%0d]", tag, i), {8'h00, shown[i]},
                   {8'h00, segs[i*7 +: 7], dps[i]});
   endtask

   task automatic hold_reset(input int n);
      for (int k = 0; k < n; k++) begin
         bus.status = 2'($urandom_range(0, 3));
         bus.pos    = 4'($urandom_range(0, 15));
         bus.dig    = 4'($urandom_range(0, 15));
         @(negedge clock);
         check_val("rst_hold", {bus.an, bus.seg, bus.dp}, 16'hFFFF);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.status = 2'b01;
      bus.pos    = 4'hF;
      bus.dig    = 4'h0;
      model_reset();
      clear_shown();
      #1 reset = 1'b0;
      #1 check_val("rst_async0", {bus.an, bus.seg, bus.dp}, 16'hFFFF);
      hold_reset(5);

      reset = 1'b1;
      run(34, 2'b01, 4'hF, 4'h0);
      scene("blank", {8{B}}, 8'hFF);

      clear_shown();
      step(2'b01, 4'd0, 4'd5);
      step(2'b01, 4'd1, 4'd2);
      run(34, 2'b01, 4'd2, 4'd1);
      scene("show125", {{5{B}}, S1, S2, S5}, 8'hFF);

      clear_shown();
      run(34, 2'b01, 4'd0, 4'd9);
      scene("frame9", {{7{B}}, S9}, 8'hFF);

      clear_shown();
      step(2'b01, 4'd0, 4'd7);
      step(2'b01, 4'd1, 4'd0);
      step(2'b01, 4'd2, 4'd0);
      run(34, 2'b01, 4'd3, 4'd0);
      scene("lz7", {{7{B}}, S7}, 8'hFF);

      clear_shown();
      for (int p = 0; p < 7; p++) step(2'b01, 4'(p), 4'd0);
      run(34, 2'b01, 4'd7, 4'd0);
      scene("lz0", {{7{B}}, S0}, 8'hFF);

      clear_shown();
      step(2'b01, 4'd0, 4'd5);
      step(2'b01, 4'd1, 4'd0);
      run(34, 2'b01, 4'd2, 4'd1);
      scene("show105", {{5{B}}, S1, S0, S5}, 8'hFF);

      clear_shown();
      run(34, 2'b00, 4'd2, 4'd1);
      scene("err", {{5{B}}, SE, SR, SR}, 8'hFF);

      clear_shown();
      run(34, 2'b01, 4'd2, 4'd1);
      scene("err_exit", {{5{B}}, S1, S0, S5}, 8'hFF);

      clear_shown();
      run(34, 2'b10, 4'd2, 4'd1);
      scene("busy", {{5{B}}, S1, S0, S5}, 8'hFE);

      run(10, 2'b11, 4'd2, 4'd1);

      for (int k = 0; k < 80; k++)
         step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      step(2'b01, 4'd0, 4'd5);
      step(2'b01, 4'd1, 4'd2);
      step(2'b01, 4'd2, 4'd1);
      for (int k = 0; k < 40 && !(midx == 5 && mdiv == 1); k++)
         step(2'b01, 4'd2, 4'd1);
      check_val("reach_idx5", 16'(midx), 16'd5);

      #2 reset = 1'b0;
      #1 check_val("rst_midscan", {bus.an, bus.seg, bus.dp}, 16'hFFFF);
      model_reset();
      @(negedge clock);
      hold_reset(3);

      reset = 1'b1;
      clear_shown();
      run(34, 2'b01, 4'hF, 4'h0);
      scene("post_rst", {8{B}}, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_display.md
# calc_display

Multiplexed 8-digit seven-segment display driver sitting directly downstream of the calculator core. It captures the core's per-cycle digit writes (`pos`, `dig`) into a digit buffer and blanks leading zeros. It overlays "Err" when the core reports error status. It time-multiplexes the buffer onto common-anode displays with active-low anodes and segments.

## Interface
- `DIGITS`, 8: number of display positions; buffer depth and anode width.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit; must be ≥ 2.
- `clock`  in  1: single system clock; all state on its rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = in reset).
- `status`  in  2: core status; 2'b00 ERRO, 2'b01 PRONTA, 2'b10 OCUPADA, 2'b11 treated as PRONTA.
- `pos`  in  4: buffer write position from core.
- `dig`  in  4: digit value from core.
- `an`  out  DIGITS: anode enables, active-low, one-hot-zero.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low.

## Operation
- **Capture.** Every cycle with `pos < DIGITS`: `buf[pos] <= dig`. `pos ≥ DIGITS` is ignored. Repeated identical writes are harmless.
- **Frame start.** `pos_q` holds the previous cycle's `pos`. When `pos == 0` and `pos_q != 0`, entries 1..DIGITS-1 become BLANK (4'hF) in that same cycle, and entry 0 takes `dig`.
- **Leading-zero blanking** (combinational on `buf`). Digit i>0 is shown blank if `buf[i]` is 0 and every `buf[j]` with j>i is 0 or >9. Digit 0 is never zero-blanked.
- **Decode.** Values 0–9 map to standard patterns: 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 5 = 7'b0010010. Values 10–15 map to blank, 7'b1111111.
- **Error overlay.** While `status == ERRO`: position 2 shows E (7'b0000110), positions 1 and 0 show r (7'b0101111), all others blank. The buffer keeps capturing underneath, and the overlay ends the cycle `status` leaves ERRO.
- **Busy dot.** `dp` = 0 only when the scan index is 0 and `status == OCUPADA`; otherwise 1.
- **Scan FSM.**
  - `div_cnt` counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and `idx` advances 0→1→…→DIGITS-1→0.
  - `an = ~(1 << idx)`. `seg` and `dp` are for position `idx`.

## Timing
- **Reset (asserted, async).**
  - Outputs: `an` = all 1, `seg` = 7'h7F, `dp` = 1.
  - State: `buf` all BLANK, `pos_q` = 0, `div_cnt` = 0, `idx` = 0.
- **First cycle after deassertion.** The first clock edge after deassertion drives `an` = ~1 for position 0.
- **Registered outputs.** `an`, `seg` and `dp` are registered. They reflect `buf`/`status`/`idx` as of the previous edge, so write-to-segment latency is 2 cycles when `idx` already points at the written position.
- **Dwell.** Each position is lit for exactly REFRESH_DIV cycles. A full frame takes DIGITS×REFRESH_DIV cycles.
- **Simultaneous events.**
  - Frame-start clear and capture of position 0 occur in the same edge.
  - A write to position `idx` in the same cycle as an `idx` advance shows the new data one cycle later.
- **Mid-operation reset.** Reset mid-scan or mid-frame forces all outputs to their reset values immediately, with no clock needed.

## Structure
- **`calc_pkg`** (shared with the calculator core) holds:
  - the status enum (ERRO/PRONTA/OCUPADA);
  - the BLANK code 4'hF;
  - segment constants for 0–9, E, r and blank.
- **`seg7_decode`** is a combinational sub-module: 4-bit value plus blank flag in, 7-bit active-low pattern out.
- The top level holds the buffer, frame-start logic, blanking, overlay and scan FSM.

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset.** Hold `reset`=0 with random inputs → `an`=8'hFF, `seg`=7'h7F, `dp`=1. Release → `an` cycles FE, FD, …, 7F, 4 cycles each, all blank.
- **Multi-digit capture.** Drive pos 0,1,2 with dig 5,2,1, then hold pos=2/dig=1 → scan shows "125". Positions 3–7 show 7'h7F.
- **Leading zeros.** Drive pos 0..3 with dig 7,0,0,0 → only position 0 is lit (pattern for 7). Drive all eight positions with 0 → only position 0 shows "0".
- **Frame start.** After "125", drive pos=0/dig=9 (previous pos=2) → positions 1–7 blank next cycle, position 0 = 9.
- **Error overlay.**
  - `status`=00 → positions 2/1/0 show E/r/r, others blank.
  - `status`=01 → buffer contents return within 2 cycles.
  - `status`=10 → `dp`=0 only while `an`=8'hFE.
- **Async reset mid-scan.** Assert `reset` while `idx`=5 with nonzero buffer → outputs go to reset values before the next clock edge. After release, the display is blank and the scan restarts at `idx`=0.
